tube_array: RTL and testbench

TUBE_ARRAY -- requirements
Module: tube_array

---
 rtl/tube_pkg.sv | 19 +
 rtl/tube_channel.sv | 62 ++++++
 rtl/tube_array.sv | 116 +++++++++++
 tb/tb_tube_array.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared definitions for the drift-tube gate/readout block.
// Readout FSM states, default parameters and the channel-index width helper.
package tube_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        READOUT = 2'd2
    } state_t;

    localparam int DEF_NUM_TUBES = 8;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_WINDOW    = 255;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tube_channel.sv
// One drift-tube channel: optional 2-flop synchroniser (TUBE_SYNC_EN), rising-edge
// detect, hit flag and drift-time capture register.
module tube_channel
    import tube_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clear,
    input  logic             arm,
    input  logic [CNT_W-1:0] cnt,
    input  logic             tube_in,
    output logic             hit,
    output logic [CNT_W-1:0] hit_time,
    output logic             rise_now
);

    logic level;
    logic level_prev;

`ifdef TUBE_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= tube_in;
            sync2 <= sync1;
        end
    end

    assign level = sync2;
`else
    assign level = tube_in;
`endif

    // History tracks the level in every state so a line already high on arming is not a rise.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) level_prev <= 1'b0;
        else        level_prev <= level;
    end

    assign rise_now = arm && !hit && level && !level_prev;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hit      <= 1'b0;
            hit_time <= '0;
        end else if (clear) begin
            hit      <= 1'b0;
            hit_time <= '0;
        end else if (rise_now) begin
            hit      <= 1'b1;
            hit_time <= cnt;
        end
    end

endmodule

// File: rtl/tube_array.sv
// Drift-tube array: a start trigger opens a gate window, per-channel drift times are
// captured, then one word per channel is streamed out. TUBE_SYNC_EN adds input synchronisers.
//
// state   | meaning
// IDLE    | waiting for start
// ARMED   | counter running, channels capturing first rising edge
// READOUT | presenting channel words 0..NUM_TUBES-1 with valid/ready
module tube_array
    import tube_pkg::*;
#(
    parameter int NUM_TUBES = DEF_NUM_TUBES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WINDOW    = DEF_WINDOW
) (
    input  logic                                clk,
    input  logic                                clr_n,
    input  logic                                start,
    input  logic [NUM_TUBES-1:0]                tube_in,
    output logic                                busy,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [chan_width(NUM_TUBES)-1:0]    out_chan,
    output logic [CNT_W-1:0]                    out_time,
    output logic                                out_hit
);

    localparam int               CHAN_W    = chan_width(NUM_TUBES);
    localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WINDOW);
    localparam logic [CHAN_W-1:0] LAST_CH  = CHAN_W'(NUM_TUBES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_TUBES-1:0] hit;
    logic [NUM_TUBES-1:0] rise_now;
    logic [CNT_W-1:0]   hit_time [NUM_TUBES];
    logic               clear;
    logic               arm;
    logic               all_hit;

    assign clear = (state == IDLE) && start;
    assign arm   = (state == ARMED);

    for (genvar g = 0; g < NUM_TUBES; g++) begin : g_ch
        tube_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .clr_n    (clr_n),
            .clear    (clear),
            .arm      (arm),
            .cnt      (cnt),
            .tube_in  (tube_in[g]),
            .hit      (hit[g]),
            .hit_time (hit_time[g]),
            .rise_now (rise_now[g])
        );
    end

    // Include this cycle's rises so the last channel to fire ends the window immediately.
    assign all_hit = &(hit | rise_now);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_chan  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARMED;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (cnt == WIN_CNT || all_hit) begin
                        state     <= READOUT;
                        out_valid <= 1'b1;
                        out_chan  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                READOUT: begin
                    if (out_ready) begin
                        if (out_chan == LAST_CH) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_chan  <= '0;
                        end else begin
                            out_chan <= out_chan + CHAN_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_chan  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        out_time = '0;
        out_hit  = 1'b0;
        if (out_valid) begin
            out_hit  = hit[out_chan];
            out_time = hit[out_chan] ? hit_time[out_chan] : WIN_CNT;
        end
    end

endmodule

// File: tb/tb_tube_array.sv
// Bench for tube_array: directed scenarios plus randomized trials checked each cycle
// against a window/first-rise model of the drift-time capture.
module tb_tube_array;

    localparam int NT  = 4;
    localparam int CW  = 8;
    localparam int WIN = 20;
`ifdef TUBE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [NT-1:0] tube_in = '0;
    logic          busy, out_valid, out_hit;
    logic [1:0]    out_chan;
    logic [CW-1:0] out_time;

    tube_array #(.NUM_TUBES(NT), .CNT_W(CW), .WINDOW(WIN)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .tube_in   (tube_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_time  (out_time),
        .out_hit   (out_hit)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    bit            lvl [NT][WIN+1];
    logic [NT-1:0] pre;
    int            exp_t [NT];
    bit            exp_h [NT];
    int            exp_end;

    bit            chk_en = 1'b0;
    logic          e_busy, e_valid, e_hit;
    logic [1:0]    e_chan;
    logic [CW-1:0] e_time;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      int'(busy),      int'(e_busy));
            check("out_valid", int'(out_valid), int'(e_valid));
            check("out_chan",  int'(out_chan),  int'(e_chan));
            check("out_time",  int'(out_time),  int'(e_time));
            check("out_hit",   int'(out_hit),   int'(e_hit));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // First rise per channel (history starts at the pre-start level), window end is the
    // last first-rise when every channel fires inside the window, else WIN.
    function automatic void compute_model();
        int  ft [NT];
        bit  all_in;
        int  mx;
        all_in = 1'b1;
        mx     = 0;
        for (int c = 0; c < NT; c++) begin
            ft[c] = 1000;
            for (int j = 0; j <= WIN; j++) begin
                bit cur, prv;
                cur = lvl[c][j];
                prv = (j == 0) ? pre[c] : lvl[c][j-1];
                if (cur && !prv && (j + L <= WIN) && ft[c] == 1000) ft[c] = j + L;
            end
            if (ft[c] > WIN) all_in = 1'b0;
            else if (ft[c] > mx) mx = ft[c];
        end
        exp_end = all_in ? mx : WIN;
        for (int c = 0; c < NT; c++) begin
            exp_h[c] = (ft[c] <= exp_end);
            exp_t[c] = exp_h[c] ? ft[c] : WIN;
        end
    endfunction

    task automatic set_idle_exp();
        e_busy = 1'b0; e_valid = 1'b0; e_chan = '0; e_time = '0; e_hit = 1'b0;
    endtask

    task automatic set_word(input int c);
        e_busy  = 1'b1;
        e_valid = 1'b1;
        e_chan  = 2'(c);
        e_time  = CW'(exp_t[c]);
        e_hit   = exp_h[c];
    endtask

    task automatic clear_lvl();
        for (int c = 0; c < NT; c++)
            for (int k = 0; k <= WIN; k++) lvl[c][k] = 1'b0;
        pre = '0;
    endtask

    task automatic do_reset(input string tag);
        clr_n = 1'b0;
        #1;
        check({tag, "_busy"},  int'(busy),      0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_chan"},  int'(out_chan),  0);
        check({tag, "_time"},  int'(out_time),  0);
        check({tag, "_hit"},   int'(out_hit),   0);
        set_idle_exp();
        start = 1'b0; out_ready = 1'b0;
        step();
        clr_n = 1'b1;
        step();
    endtask

    task automatic run_trial(input int rmode, input bit noise, input int rst_k, input int rst_chan);
        int chan, n, hold;
        bit r, aborted;
        compute_model();
        set_idle_exp();
        start = 1'b0; tube_in = pre;
        repeat (3) step();
        start = 1'b1; e_busy = 1'b1;
        step();
        aborted = 1'b0;
        for (int k = 0; k <= exp_end; k++) begin
            if (k == rst_k) begin
                do_reset("rst_armed");
                aborted = 1'b1;
                break;
            end
            for (int c = 0; c < NT; c++) tube_in[c] = lvl[c][k];
            start = noise ? 1'($urandom) : 1'b0;
            if (k == exp_end) set_word(0);
            step();
        end
        if (!aborted) begin
            chan = 0; n = 0; hold = 0;
            while (chan < NT && n < 100) begin
                if (chan == rst_chan) begin
                    do_reset("rst_readout");
                    aborted = 1'b1;
                    break;
                end
                case (rmode)
                    0: r = 1'b1;
                    1: r = ($urandom_range(0, 2) != 0);
                    default: begin
                        r = !(chan == 1 && hold < 3);
                        if (!r) hold++;
                    end
                endcase
                out_ready = r;
                tube_in   = NT'($urandom);
                start     = noise ? 1'($urandom) : 1'b0;
                if (r) begin
                    chan++;
                    if (chan == NT) set_idle_exp();
                    else set_word(chan);
                end
                n++;
                step();
            end
            if (!aborted && chan < NT) check("readout_timeout", chan, NT);
        end
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle_exp();
        chk_en = 1'b1;
        clear_lvl();
        step();
        step();
        clr_n = 1'b1;
        step();

        // rises on ch1 at 5 and ch3 at 12
        clear_lvl();
        for (int k = 0; k <= WIN; k++) begin
            lvl[1][k] = (k >= 5);
            lvl[3][k] = (k >= 12);
        end
        compute_model();
        check("pin32_t0", exp_t[0], 20);
        check("pin32_h0", int'(exp_h[0]), 0);
        check("pin32_t1", exp_t[1], 5 + L);
        check("pin32_t3", exp_t[3], 12 + L);
        run_trial(0, 1'b0, -1, -1);
        run_trial(2, 1'b0, -1, -1);
        run_trial(0, 1'b0, 10, -1);
        run_trial(1, 1'b0, -1, -1);

        // all four channels fire early
        clear_lvl();
        for (int k = 0; k <= WIN; k++) begin
            lvl[0][k] = (k >= 2);
            lvl[1][k] = (k >= 3);
            lvl[2][k] = (k >= 4);
            lvl[3][k] = (k >= 7);
        end
        compute_model();
        check("pin33_end", exp_end, 7 + L);
        check("pin33_t0", exp_t[0], 2 + L);
        check("pin33_t3", exp_t[3], 7 + L);
        run_trial(0, 1'b0, -1, -1);
        run_trial(1, 1'b0, -1, 2);
        run_trial(0, 1'b0, -1, -1);

        // ch0 already high before start, falls at 3, rises at 9; start noise in ARMED
        clear_lvl();
        pre = 4'b0001;
        for (int k = 0; k <= WIN; k++) lvl[0][k] = (k < 3) || (k >= 9);
        compute_model();
        check("pin35_t0", exp_t[0], 9 + L);
        check("pin35_h0", int'(exp_h[0]), 1);
        run_trial(0, 1'b1, -1, -1);

        // ch2 rises sampled at 6
        clear_lvl();
        for (int k = 0; k <= WIN; k++) lvl[2][k] = (k >= 6);
        compute_model();
        check("pin37_t2", exp_t[2], 6 + L);
        run_trial(0, 1'b0, -1, -1);

        for (int t = 0; t < 40; t++) begin
            pre = NT'($urandom);
            for (int c = 0; c < NT; c++) begin
                int  p;
                bit  v;
                p = $urandom_range(2, 30);
                v = pre[c];
                for (int k = 0; k <= WIN; k++) begin
                    if ($urandom_range(0, 99) < p) v = ~v;
                    lvl[c][k] = v;
                end
            end
            run_trial($urandom_range(0, 2), 1'($urandom), -1, -1);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
